// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder.
// UART_CMD_CHECKSUM_EN selects the 5-byte checksummed frame; otherwise 4 bytes.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    HUNT,
    ADDR,
    DHI,
    DLO,
    CSUM,
    WRITE,
    ACK_WAIT,
    NAK_WAIT,
    SEND
  } state_t;

  localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h5A;
  localparam logic [7:0] DEF_NAK_BYTE = 8'hEE;

`ifdef UART_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                            input logic [7:0] dhi,
                                            input logic [7:0] dlo);
    return addr ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// Byte receive, reply transmit and register-write signals of the command decoder.
// The master side is the decoder; the slave side is the UART and register bank.
interface uart_cmd_if;
  logic [7:0]  rx_reg;
  logic        rx_ready;
  logic        FE;
  logic        tx_ready;
  logic        tx_ena;
  logic [7:0]  tx_data;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [7:0]  err_cnt;

  modport master (
    input  rx_reg, rx_ready, FE, tx_ready,
    output tx_ena, tx_data, reg_we, reg_addr, reg_wdata, err_cnt
  );

  modport slave (
    output rx_reg, rx_ready, FE, tx_ready,
    input  tx_ena, tx_data, reg_we, reg_addr, reg_wdata, err_cnt
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle timer: reloads on clr or while disabled, counts down while enabled,
// and pulses expired once the full idle budget has elapsed.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles UART bytes into register-write frames, issues the write and replies ACK/NAK.
// UART_CMD_CHECKSUM_EN adds the trailing checksum byte and checksum-mismatch NAK.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter logic [7:0] HDR_BYTE       = DEF_HDR_BYTE,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] NAK_BYTE       = DEF_NAK_BYTE
) (
  input  logic     clk_10M,
  input  logic     rst,
  uart_cmd_if.master bus
);

  state_t      state_q, state_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [7:0]  dhi_sh_q, dhi_sh_d;
  logic [7:0]  dlo_sh_q, dlo_sh_d;
  logic        reg_we_q, reg_we_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        tx_ena_q, tx_ena_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_inc;
  logic        in_frame;
  logic        byte_ok;
  logic        expired;

  assign in_frame = (state_q == ADDR) || (state_q == DHI) ||
                    (state_q == DLO)  || (state_q == CSUM);
  assign byte_ok  = bus.rx_ready && !bus.FE;

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk_10M),
    .rst     (rst),
    .clr     (bus.rx_ready),
    .en      (in_frame),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    addr_sh_d   = addr_sh_q;
    dhi_sh_d    = dhi_sh_q;
    dlo_sh_d    = dlo_sh_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_ena_d    = 1'b0;
    tx_data_d   = tx_data_q;
    err_inc     = 1'b0;

    unique case (state_q)
      HUNT: if (byte_ok && bus.rx_reg == HDR_BYTE) state_d = ADDR;
      ADDR: if (byte_ok) begin
        addr_sh_d = bus.rx_reg;
        state_d   = DHI;
      end
      DHI: if (byte_ok) begin
        dhi_sh_d = bus.rx_reg;
        state_d  = DLO;
      end
      DLO: if (byte_ok) begin
        dlo_sh_d = bus.rx_reg;
`ifdef UART_CMD_CHECKSUM_EN
        state_d  = CSUM;
`else
        state_d  = WRITE;
`endif
      end
`ifdef UART_CMD_CHECKSUM_EN
      CSUM: if (byte_ok) begin
        if (bus.rx_reg == frame_csum(addr_sh_q, dhi_sh_q, dlo_sh_q)) begin
          state_d = WRITE;
        end else begin
          state_d   = NAK_WAIT;
          tx_data_d = NAK_BYTE;
          err_inc   = 1'b1;
        end
      end
`endif
      // Two cycles here so the strobe is a registered one-cycle pulse before the reply.
      WRITE: if (!reg_we_q) begin
        reg_we_d    = 1'b1;
        reg_addr_d  = addr_sh_q;
        reg_wdata_d = {dhi_sh_q, dlo_sh_q};
      end else begin
        state_d   = ACK_WAIT;
        tx_data_d = ACK_BYTE;
      end
      ACK_WAIT, NAK_WAIT: if (bus.tx_ready) begin
        state_d  = SEND;
        tx_ena_d = 1'b1;
      end
      SEND:    state_d = HUNT;
      default: state_d = HUNT;
    endcase

    // FE beats a same-cycle byte; a same-cycle byte beats the timeout.
    if (in_frame) begin
      if (bus.FE) begin
        state_d   = NAK_WAIT;
        tx_data_d = NAK_BYTE;
        err_inc   = 1'b1;
      end else if (!bus.rx_ready && expired) begin
        state_d = HUNT;
        err_inc = 1'b1;
      end
    end

    err_cnt_d = err_cnt_q;
    if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_10M or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      addr_sh_q   <= '0;
      dhi_sh_q    <= '0;
      dlo_sh_q    <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      tx_ena_q    <= 1'b0;
      tx_data_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_sh_q   <= addr_sh_d;
      dhi_sh_q    <= dhi_sh_d;
      dlo_sh_q    <= dlo_sh_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      tx_ena_q    <= tx_ena_d;
      tx_data_q   <= tx_data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.reg_we    = reg_we_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.tx_ena    = tx_ena_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
